// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencing controller.
// State encoding is fixed so it can be probed from outside the block.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'b00,
        ST_RELEASE = 2'b01,
        ST_RUN     = 2'b10
    } state_t;

    function automatic int cnt_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return $clog2(m + 1);
    endfunction

    function automatic int idx_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Up-counter shared by HOLD and RELEASE; expire pulses on the cycle the
// count sits at the terminal value, and the count wraps to zero there.
module rst_seq_timer #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         expire
);

    logic [W-1:0] cnt;

    assign expire = en && (cnt == term);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt <= '0;
        end else if (clr || expire) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Holds all domain resets, releases them one by one in index order, and
// re-runs the sequence on a software request with a one-cycle ack.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 3,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SW_RST_REQ,
    input  logic [NUM_DOMAINS-1:0] DOMAIN_EN,
    output logic [NUM_DOMAINS-1:0] RST_OUT,
    output logic                   SEQ_DONE,
    output logic                   BUSY,
    output logic                   SW_RST_ACK
);

    localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int IW = idx_width(NUM_DOMAINS);

    localparam logic [CW-1:0] HOLD_TERM = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_TERM  = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DOMAINS - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          idx_nxt;
    logic [NUM_DOMAINS-1:0] rst_nxt;
    logic                   sw_pend;
    logic                   pend_nxt;
    logic                   armed;
    logic                   armed_nxt;
    logic                   ack_nxt;

    logic          trig;
    logic          expire;
    logic          tmr_clr;
    logic          tmr_en;
    logic          last_rel;
    logic [CW-1:0] tmr_term;

    // armed makes a held-high request count only once
    assign trig     = SW_RST_REQ & armed;
    assign tmr_en   = (state != ST_RUN);
    assign tmr_term = (state == ST_HOLD) ? HOLD_TERM : GAP_TERM;
    assign tmr_clr  = trig && (state != ST_HOLD);
    assign last_rel = (state == ST_RELEASE) && expire && (idx == LAST_IDX);

    rst_seq_timer #(
        .W(CW)
    ) u_timer (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .term  (tmr_term),
        .expire(expire)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= ST_HOLD;
            idx        <= '0;
            RST_OUT    <= '0;
            SEQ_DONE   <= 1'b0;
            BUSY       <= 1'b1;
            SW_RST_ACK <= 1'b0;
            sw_pend    <= 1'b0;
            armed      <= 1'b1;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            RST_OUT    <= rst_nxt;
            SEQ_DONE   <= (state_nxt == ST_RUN);
            BUSY       <= (state_nxt != ST_RUN);
            SW_RST_ACK <= ack_nxt;
            sw_pend    <= pend_nxt;
            armed      <= armed_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_HOLD: begin
                if (expire) state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (trig)          state_nxt = ST_HOLD;
                else if (last_rel) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (trig) state_nxt = ST_HOLD;
            end
            default: state_nxt = ST_HOLD;
        endcase
    end

    always_comb begin
        rst_nxt  = RST_OUT;
        idx_nxt  = idx;
        ack_nxt  = 1'b0;
        pend_nxt = sw_pend | trig;
        if (!SW_RST_REQ) armed_nxt = 1'b1;
        else if (trig)   armed_nxt = 1'b0;
        else             armed_nxt = armed;
        unique case (state)
            ST_HOLD: begin
                rst_nxt = '0;
                if (expire) idx_nxt = '0;
            end
            ST_RELEASE: begin
                if (trig) begin
                    rst_nxt = '0;
                    idx_nxt = '0;
                end else if (expire) begin
                    for (int k = 0; k < NUM_DOMAINS; k++) begin
                        if (idx == IW'(k)) rst_nxt[k] = DOMAIN_EN[k];
                    end
                    idx_nxt = idx + 1'b1;
                    if (last_rel) begin
                        ack_nxt  = sw_pend;
                        pend_nxt = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                // a dropped enable re-asserts; re-enabling waits for a sequence
                rst_nxt = RST_OUT & DOMAIN_EN;
                if (trig) begin
                    rst_nxt = '0;
                    idx_nxt = '0;
                end
            end
            default: begin
                rst_nxt = '0;
                idx_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed scenarios push expected output changes into queues; a monitor
// pops and compares whenever a DUT's outputs change.
module tb_rst_seq_ctrl;

    typedef struct {
        int         cyc;
        logic [2:0] ro;
        logic       done;
        logic       busy;
        logic       ack;
    } exp_t;

    logic       CLK;
    logic       RST;
    logic       SW_RST_REQ;
    logic [2:0] DOMAIN_EN;
    logic [2:0] RST_OUT;
    logic       SEQ_DONE;
    logic       BUSY;
    logic       SW_RST_ACK;

    logic       rst1;
    logic       req1;
    logic [0:0] en1;
    logic [0:0] ro1;
    logic       done1;
    logic       busy1;
    logic       ack1;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic mon0_en = 1'b0;
    logic mon1_en = 1'b0;
    logic chk_tog = 1'b0;

    rst_seq_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .SW_RST_REQ(SW_RST_REQ),
        .DOMAIN_EN (DOMAIN_EN),
        .RST_OUT   (RST_OUT),
        .SEQ_DONE  (SEQ_DONE),
        .BUSY      (BUSY),
        .SW_RST_ACK(SW_RST_ACK)
    );

    rst_seq_ctrl #(
        .NUM_DOMAINS(1),
        .HOLD_CYCLES(1),
        .GAP_CYCLES (1)
    ) dut1 (
        .CLK       (CLK),
        .RST       (rst1),
        .SW_RST_REQ(req1),
        .DOMAIN_EN (en1),
        .RST_OUT   (ro1),
        .SEQ_DONE  (done1),
        .BUSY      (busy1),
        .SW_RST_ACK(ack1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
        end
    end

    task automatic push0(input int c, input logic [2:0] ro,
                         input logic d, input logic b, input logic a);
        exp_t e;
        e.cyc = c; e.ro = ro; e.done = d; e.busy = b; e.ack = a;
        q0.push_back(e);
    endtask

    task automatic push1(input int c, input logic [2:0] ro,
                         input logic d, input logic b, input logic a);
        exp_t e;
        e.cyc = c; e.ro = ro; e.done = d; e.busy = b; e.ack = a;
        q1.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic drained;
        chk_tog = ~chk_tog;
        tick(2);
    endtask

    function automatic void compare(input string nm, input int ch,
                                    input exp_t e, input exp_t g);
        checks++;
        if ((e.cyc >= 0 && e.cyc != g.cyc) || e.ro != g.ro ||
            e.done != g.done || e.busy != g.busy || e.ack != g.ack) begin
            errors++;
            $display("FAIL %s#%0d got cyc=%0d ro=%b done=%b busy=%b ack=%b, exp cyc=%0d ro=%b done=%b busy=%b ack=%b",
                     nm, ch, g.cyc, g.ro, g.done, g.busy, g.ack,
                     e.cyc, e.ro, e.done, e.busy, e.ack);
        end
    endfunction

    // Monitor: one process owns the counters
    initial begin
        exp_t g0, p0, g1, p1, e;
        logic pv0, pv1, seen;
        pv0 = 1'b0; pv1 = 1'b0; seen = 1'b0;
        p0 = '{0, 3'b0, 1'b0, 1'b0, 1'b0};
        p1 = p0;
        forever begin
            @(negedge CLK);
            if (mon0_en) begin
                g0 = '{cyc, RST_OUT, SEQ_DONE, BUSY, SW_RST_ACK};
                if (!pv0 || g0.ro != p0.ro || g0.done != p0.done ||
                    g0.busy != p0.busy || g0.ack != p0.ack) begin
                    if (q0.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL out0 unexpected change cyc=%0d ro=%b done=%b busy=%b ack=%b",
                                 g0.cyc, g0.ro, g0.done, g0.busy, g0.ack);
                    end else begin
                        e = q0.pop_front();
                        compare("out0", checks, e, g0);
                    end
                end
                p0 = g0; pv0 = 1'b1;
            end
            if (mon1_en) begin
                g1 = '{cyc, {2'b00, ro1}, done1, busy1, ack1};
                if (!pv1 || g1.ro != p1.ro || g1.done != p1.done ||
                    g1.busy != p1.busy || g1.ack != p1.ack) begin
                    if (q1.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL out1 unexpected change cyc=%0d ro=%b done=%b busy=%b ack=%b",
                                 g1.cyc, g1.ro, g1.done, g1.busy, g1.ack);
                    end else begin
                        e = q1.pop_front();
                        compare("out1", checks, e, g1);
                    end
                end
                p1 = g1; pv1 = 1'b1;
            end
            if (chk_tog != seen) begin
                seen = chk_tog;
                checks++;
                if (q0.size() + q1.size() != 0) begin
                    errors++;
                    $display("FAIL missing_events got pending=%0d required=0",
                             q0.size() + q1.size());
                    q0.delete();
                    q1.delete();
                end
            end
        end
    end

    initial begin
        int b;
        RST = 1'b0; SW_RST_REQ = 1'b0; DOMAIN_EN = 3'b111;
        rst1 = 1'b0; req1 = 1'b0; en1 = 1'b1;

        // power-on sequence, no ack
        push0(-1, 3'b000, 1'b0, 1'b1, 1'b0);
        mon0_en = 1'b1;
        tick(3);
        RST = 1'b1; b = cyc;
        push0(b + 12, 3'b001, 1'b0, 1'b1, 1'b0);
        push0(b + 16, 3'b011, 1'b0, 1'b1, 1'b0);
        push0(b + 20, 3'b111, 1'b1, 1'b0, 1'b0);
        tick(25);
        drained();

        // software reset from RUN, request held for 30 cycles
        SW_RST_REQ = 1'b1; b = cyc;
        push0(b + 1,  3'b000, 1'b0, 1'b1, 1'b0);
        push0(b + 13, 3'b001, 1'b0, 1'b1, 1'b0);
        push0(b + 17, 3'b011, 1'b0, 1'b1, 1'b0);
        push0(b + 21, 3'b111, 1'b1, 1'b0, 1'b1);
        push0(b + 22, 3'b111, 1'b1, 1'b0, 1'b0);
        tick(30);
        SW_RST_REQ = 1'b0;
        tick(10);
        drained();

        // disabled domain stays in reset; re-enable does not release
        RST = 1'b0; DOMAIN_EN = 3'b101; b = cyc;
        push0(b + 1, 3'b000, 1'b0, 1'b1, 1'b0);
        tick(2);
        RST = 1'b1; b = cyc;
        push0(b + 12, 3'b001, 1'b0, 1'b1, 1'b0);
        push0(b + 20, 3'b101, 1'b1, 1'b0, 1'b0);
        tick(25);
        DOMAIN_EN = 3'b100; b = cyc;
        push0(b + 1, 3'b100, 1'b1, 1'b0, 1'b0);
        tick(3);
        DOMAIN_EN = 3'b101;
        tick(10);
        drained();

        // request mid-release restarts from HOLD
        RST = 1'b0; DOMAIN_EN = 3'b111; b = cyc;
        push0(b + 1, 3'b000, 1'b0, 1'b1, 1'b0);
        tick(2);
        RST = 1'b1; b = cyc;
        push0(b + 12, 3'b001, 1'b0, 1'b1, 1'b0);
        push0(b + 15, 3'b000, 1'b0, 1'b1, 1'b0);
        push0(b + 27, 3'b001, 1'b0, 1'b1, 1'b0);
        push0(b + 31, 3'b011, 1'b0, 1'b1, 1'b0);
        push0(b + 35, 3'b111, 1'b1, 1'b0, 1'b1);
        push0(b + 36, 3'b111, 1'b1, 1'b0, 1'b0);
        tick(14);
        SW_RST_REQ = 1'b1;
        tick(1);
        SW_RST_REQ = 1'b0;
        tick(25);
        drained();

        // reset beats a simultaneous request; no ack afterwards
        RST = 1'b0; b = cyc;
        push0(b + 1, 3'b000, 1'b0, 1'b1, 1'b0);
        tick(2);
        RST = 1'b1; b = cyc;
        push0(b + 12, 3'b001, 1'b0, 1'b1, 1'b0);
        push0(b + 16, 3'b011, 1'b0, 1'b1, 1'b0);
        push0(b + 17, 3'b000, 1'b0, 1'b1, 1'b0);
        push0(b + 29, 3'b001, 1'b0, 1'b1, 1'b0);
        push0(b + 33, 3'b011, 1'b0, 1'b1, 1'b0);
        push0(b + 37, 3'b111, 1'b1, 1'b0, 1'b0);
        tick(16);
        RST = 1'b0; SW_RST_REQ = 1'b1;
        tick(1);
        RST = 1'b1; SW_RST_REQ = 1'b0;
        tick(25);
        drained();

        // minimal configuration: one domain, one-cycle hold and gap
        rst1 = 1'b1; b = cyc;
        push1(b + 1, 3'b000, 1'b0, 1'b1, 1'b0);
        push1(b + 2, 3'b001, 1'b1, 1'b0, 1'b0);
        mon1_en = 1'b1;
        tick(6);
        drained();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset sequencing controller in the reference-clock domain, driven by the synchronized system reset.
- Holds all downstream domain resets asserted for a fixed time, then releases them one at a time in index order with a fixed gap.
- Serves a software reset request/acknowledge handshake that re-runs the full sequence.
- Sits between the reset synchronizer output and the per-domain reset inputs (UART TX/RX, register file, ALU domains).

Parameters:
NUM_DOMAINS, 3, number of sequenced domain resets (>=1)
HOLD_CYCLES, 8, cycles all resets stay asserted before sequencing (>=1)
GAP_CYCLES, 4, cycles between consecutive domain releases (>=1)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous, active-low reset
SW_RST_REQ  input  1  software reset request, level; held high until SW_RST_ACK
DOMAIN_EN  input  NUM_DOMAINS  per-domain enable; a disabled domain is never released
RST_OUT  output  NUM_DOMAINS  per-domain active-low resets; bit 0 released first
SEQ_DONE  output  1  high while in RUN
BUSY  output  1  high in HOLD and RELEASE
SW_RST_ACK  output  1  one-cycle pulse when a software-triggered sequence completes

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-low. RST low at a rising edge dominates every other input.
- Reset values: state=HOLD, cnt=0, idx=0, RST_OUT=0, SEQ_DONE=0, BUSY=1, SW_RST_ACK=0, sw_pend=0, armed=1.
- Counter width is $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1); idx width is $clog2(NUM_DOMAINS+1).
- Registered outputs: BUSY=(state!=RUN), SEQ_DONE=(state==RUN).
- HOLD:
  - RST_OUT=0 and cnt increments every cycle.
  - On the edge where cnt reaches HOLD_CYCLES-1: go to RELEASE with cnt=0, idx=0.
- RELEASE:
  - cnt increments every cycle.
  - When cnt==GAP_CYCLES-1: RST_OUT[idx]<=DOMAIN_EN[idx], idx++, cnt=0.
  - On the edge releasing idx=NUM_DOMAINS-1: go to RUN.
  - On that same edge SW_RST_ACK<=sw_pend and sw_pend<=0.
- Timing from reset: with edge 1 as the first edge with RST=1, RELEASE is entered at edge HOLD_CYCLES. Domain k releases at edge HOLD_CYCLES+(k+1)*GAP_CYCLES.
- RUN:
  - RST_OUT[k]<=RST_OUT[k]&DOMAIN_EN[k]. Clearing DOMAIN_EN[k] asserts that reset on the next edge.
  - Re-setting DOMAIN_EN[k] does not release the domain; release only happens in the next sequence.
- SW request trigger (trig) = SW_RST_REQ & armed.
  - armed is cleared on trig and set whenever SW_RST_REQ=0. One request therefore causes exactly one sequence.
- trig in RUN or RELEASE: next edge goes to HOLD with RST_OUT=0, cnt=0, sw_pend=1. A sequence interrupted mid-release restarts from scratch.
- trig in HOLD: sw_pend=1; cnt is not restarted.
- SW_RST_ACK is exactly one cycle wide and is only generated at a RUN entry with sw_pend=1. No ACK is generated after a power-on/RST-driven sequence.
- Simultaneous events:
  - RST low together with trig: reset wins and sw_pend=0.
  - trig together with the last-release edge: trig wins, the block goes to HOLD and no ACK is issued.
- Mid-operation RST low: all outputs return to their reset values on that edge.

Decomposition:
- Package rst_seq_pkg holds:
  - the state encoding (HOLD=2'b00, RELEASE=2'b01, RUN=2'b10);
  - a width-calculation function for cnt/idx.
- One sub-module, rst_seq_timer:
  - loadable up-counter with inputs clr/en and terminal value;
  - single-cycle expire output;
  - instantiated once and shared by HOLD and RELEASE.

Test Plan:
- Defaults, RST low for 3 cycles then high, DOMAIN_EN=3'b111 -> RST_OUT steps 000->001 at edge 12, 011 at 16, 111 at 20. SEQ_DONE=1 and BUSY=0 from edge 20; SW_RST_ACK never pulses.
- In RUN, SW_RST_REQ held high for 30 cycles -> RST_OUT=000 next edge, full sequence re-runs. SW_RST_ACK pulses exactly once, on the edge RST_OUT becomes 111; no second sequence while REQ stays high.
- DOMAIN_EN=3'b101 -> RST_OUT[1] stays 0 throughout; after the sequence RST_OUT=101. Clearing DOMAIN_EN[0] in RUN gives RST_OUT=100 next edge, and it stays 100 after re-setting it.
- SW_RST_REQ pulsed at edge 14 (after domain 0 released) -> RST_OUT=000 at edge 15 and HOLD restarts. Domain 0 releases at edge 15+8+4=27; ACK pulses at edge 35.
- RST driven low at edge 17 mid-RELEASE with SW_RST_REQ high -> all outputs at reset values on that edge, and no ACK is produced for that request.
- Parameter sweep NUM_DOMAINS=1, HOLD_CYCLES=1, GAP_CYCLES=1 -> RST_OUT[0] releases at edge 2, SEQ_DONE=1 at edge 2.
